// File: rtl/ita_gelu_requant.sv
// Requantizer behind the GELU stage: multiply by an unsigned eps multiplier,
// apply a rounding arithmetic right shift, add a signed offset and saturate back
// to WI bits. Three-stage valid/ready pipeline with a tile element counter.
module ita_gelu_requant #(
  parameter int IN_W    = 26,
  parameter int WI      = 8,
  parameter int MULT_W  = 8,
  parameter int SHIFT_W = 5,
  parameter int LEN_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [IN_W-1:0]    data_i,
  input  logic [MULT_W-1:0]  mult_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [WI-1:0]      add_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WI-1:0]      data_o,
  output logic               last_o
);

  // Product width, plus one guard bit for the rounding add, plus one for the offset add.
  localparam int PW = IN_W + MULT_W + 1;
  localparam int GW = PW + 1;
  localparam int SW = GW + 1;

  localparam logic signed [SW-1:0] C_MAX = SW'(2 ** (WI - 1) - 1);
  localparam logic signed [SW-1:0] C_MIN = -C_MAX - SW'(1);

  // Stage registers.
  logic                      r_v1, r_v2, r_v3;
  logic signed [PW-1:0]      r_s1Prod;
  logic [SHIFT_W-1:0]        r_s1Shift;
  logic signed [WI-1:0]      r_s1Add;
  logic [LEN_W-1:0]          r_s1LenM1;
  logic signed [SW-1:0]      r_s2Sum;
  logic [LEN_W-1:0]          r_s2LenM1;
  logic [WI-1:0]             r_data3;
  logic [LEN_W-1:0]          r_len3;

  // Tile bookkeeping: input side finds tile boundaries, output side counts transfers.
  logic                      r_tileStart;
  logic [LEN_W-1:0]          r_inCnt;
  logic [LEN_W-1:0]          r_lenM1Q;
  logic [LEN_W-1:0]          r_outCnt;

  logic                      w_rdy1, w_rdy2, w_rdy3;
  logic                      w_inFire, w_outFire;
  logic [LEN_W-1:0]          w_lenM1In, w_elemLenM1;
  logic                      w_inLast;
  logic signed [PW-1:0]      w_prodA, w_prodB, w_prod;
  logic signed [GW-1:0]      w_ext, w_bias, w_rnd, w_shr;
  logic signed [SW-1:0]      w_sum;
  logic [WI-1:0]             w_sat;

  // Backpressure chain: a stage can load when empty or when its content leaves this cycle.
  assign w_rdy3    = !r_v3 || ready_i;
  assign w_rdy2    = !r_v2 || w_rdy3;
  assign w_rdy1    = !r_v1 || w_rdy2;
  assign ready_o   = w_rdy1 && !rst_i;
  assign w_inFire  = valid_i && ready_o;
  assign w_outFire = r_v3 && ready_i;

  // Tile length travels with each element as (len-1); a length of zero behaves as one.
  assign w_lenM1In   = (len_i == '0) ? '0 : len_i - LEN_W'(1);
  assign w_elemLenM1 = r_tileStart ? w_lenM1In : r_lenM1Q;
  assign w_inLast    = (r_inCnt == w_elemLenM1);

  // Signed data times zero-extended unsigned multiplier.
  assign w_prodA = PW'($signed(data_i));
  assign w_prodB = PW'({1'b0, mult_i});
  assign w_prod  = w_prodA * w_prodB;

  // Round half toward +inf: add 2^(shift-1) in a widened word, then shift arithmetically.
  assign w_ext  = GW'(r_s1Prod);
  assign w_bias = (r_s1Shift == '0) ? '0 : (GW'(1) << (r_s1Shift - SHIFT_W'(1)));
  assign w_rnd  = w_ext + w_bias;
  assign w_shr  = w_rnd >>> r_s1Shift;
  assign w_sum  = SW'(w_shr) + SW'(r_s1Add);

  // Clamp into the signed WI-bit range.
  assign w_sat = (r_s2Sum > C_MAX) ? C_MAX[WI-1:0] :
                 (r_s2Sum < C_MIN) ? C_MIN[WI-1:0] : r_s2Sum[WI-1:0];

  assign valid_o = r_v3;
  assign data_o  = r_data3;
  assign last_o  = r_v3 && (r_outCnt == r_len3);

  // Stage 1: capture the element with its per-element constants and form the product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1      <= 1'b0;
      r_s1Prod  <= '0;
      r_s1Shift <= '0;
      r_s1Add   <= '0;
      r_s1LenM1 <= '0;
    end else if (w_rdy1) begin
      r_v1      <= valid_i;
      r_s1Prod  <= w_prod;
      r_s1Shift <= shift_i;
      r_s1Add   <= add_i;
      r_s1LenM1 <= w_elemLenM1;
    end
  end

  // Stage 2: rounding shift and offset add.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v2      <= 1'b0;
      r_s2Sum   <= '0;
      r_s2LenM1 <= '0;
    end else if (w_rdy2) begin
      r_v2      <= r_v1;
      r_s2Sum   <= w_sum;
      r_s2LenM1 <= r_s1LenM1;
    end
  end

  // Stage 3: saturate into the output register, which holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v3    <= 1'b0;
      r_data3 <= '0;
      r_len3  <= '0;
    end else if (w_rdy3) begin
      r_v3    <= r_v2;
      r_data3 <= w_sat;
      r_len3  <= r_s2LenM1;
    end
  end

  // Input-side tile tracking: sample the length at the first element of each tile.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tileStart <= 1'b1;
      r_inCnt     <= '0;
      r_lenM1Q    <= '0;
    end else if (w_inFire) begin
      if (r_tileStart) begin
        r_lenM1Q <= w_lenM1In;
      end
      if (w_inLast) begin
        r_tileStart <= 1'b1;
        r_inCnt     <= '0;
      end else begin
        r_tileStart <= 1'b0;
        r_inCnt     <= r_inCnt + LEN_W'(1);
      end
    end
  end

  // Output element counter, returning to zero when the tile's last element leaves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outCnt <= '0;
    end else if (w_outFire) begin
      if (last_o) begin
        r_outCnt <= '0;
      end else begin
        r_outCnt <= r_outCnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ita_gelu_requant.sv
// Randomised bench for ita_gelu_requant with a behavioural requant/tile model.
module tb_ita_gelu_requant;

  localparam int IN_W    = 26;
  localparam int WI      = 8;
  localparam int MULT_W  = 8;
  localparam int SHIFT_W = 5;
  localparam int LEN_W   = 16;
  localparam longint OUT_MAX = (longint'(1) << (WI - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) << (WI - 1));

  logic               clk = 1'b0;
  logic               rst_i;
  logic               valid_i;
  logic               ready_o;
  logic [IN_W-1:0]    data_i;
  logic [MULT_W-1:0]  mult_i;
  logic [SHIFT_W-1:0] shift_i;
  logic [WI-1:0]      add_i;
  logic [LEN_W-1:0]   len_i;
  logic               valid_o;
  logic               ready_i;
  logic [WI-1:0]      data_o;
  logic               last_o;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  ita_gelu_requant #(
    .IN_W(IN_W), .WI(WI), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .mult_i(mult_i), .shift_i(shift_i), .add_i(add_i),
    .len_i(len_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o)
  );

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int errors = 0;

  bit                 drvValid = 1'b0;
  logic [IN_W-1:0]    drvData  = '0;
  logic [MULT_W-1:0]  drvMult  = '0;
  logic [SHIFT_W-1:0] drvShift = '0;
  logic [WI-1:0]      drvAdd   = '0;
  logic [LEN_W-1:0]   drvLen   = '0;
  int  rdyMode = 0;
  bit  rdyVal  = 1'b1;
  bit  accepted;
  bit  holdPending = 1'b0;
  longint heldData;
  bit  heldLast;
  bit  mTileStart = 1'b1;
  int  mIdx = 0;
  int  mLen = 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Requantization straight from the arithmetic definition.
  function automatic longint refRequant(longint d, longint m, int sh, longint a);
    longint p, r, s;
    p = d * m;
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    s = r + a;
    if (s > OUT_MAX) s = OUT_MAX;
    else if (s < OUT_MIN) s = OUT_MIN;
    return s;
  endfunction

  // Record an accepted element: its value and whether it closes its tile.
  task automatic modelAccept();
    exp_t e;
    if (mTileStart) begin
      mLen = (drvLen == '0) ? 1 : int'(drvLen);
      mIdx = 0;
      mTileStart = 1'b0;
    end
    e.data = refRequant(longint'($signed(drvData)), longint'(drvMult), int'(drvShift),
                        longint'($signed(drvAdd)));
    e.last = (mIdx == mLen - 1);
    if (e.last) begin
      mTileStart = 1'b1;
      mIdx = 0;
    end else begin
      mIdx++;
    end
    expQ.push_back(e);
  endtask

  // One clock cycle: drive at the falling edge, observe the settled values 1 unit later.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    valid_i = drvValid;
    data_i  = drvData;
    mult_i  = drvMult;
    shift_i = drvShift;
    add_i   = drvAdd;
    len_i   = drvLen;
    if (rdyMode == 1) ready_i = 1'($urandom_range(0, 1));
    else ready_i = rdyVal;
    #1;
    if (holdPending) begin
      checkOutput("hold_valid", longint'(valid_o), 1);
      checkOutput("hold_data", longint'($signed(data_o)), heldData);
      checkOutput("hold_last", longint'(last_o), longint'(heldLast));
      holdPending = 1'b0;
    end
    if (valid_o && ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("data", longint'($signed(data_o)), e.data);
        checkOutput("last", longint'(last_o), longint'(e.last));
      end
    end else if (valid_o) begin
      holdPending = 1'b1;
      heldData = longint'($signed(data_o));
      heldLast = last_o;
    end
    accepted = valid_i && ready_o;
    if (accepted) modelAccept();
  endtask

  task automatic applyStimulus(input longint d, input int m, input int sh, input int a, input int len);
    int n;
    drvData  = IN_W'(d);
    drvMult  = MULT_W'(m);
    drvShift = SHIFT_W'(sh);
    drvAdd   = WI'(a);
    drvLen   = LEN_W'(len);
    drvValid = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      tick();
      n++;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    drvValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drvValid = 1'b0;
    while ((expQ.size() != 0 || valid_o) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("drain_left", longint'(expQ.size()), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    checkOutput("reset_ready_o", longint'(ready_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checkOutput("reset_valid_o", longint'(valid_o), 0);
    checkOutput("reset_data_o", longint'(data_o), 0);
    checkOutput("reset_last_o", longint'(last_o), 0);
    checkOutput("post_reset_ready_o", longint'(ready_o), 1);
    expQ.delete();
    holdPending = 1'b0;
    mTileStart  = 1'b1;
    mIdx        = 0;
  endtask

  // Test sequence.
  initial begin
    int sent;
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    data_i = '0; mult_i = '0; shift_i = '0; add_i = '0; len_i = '0;
    doReset();

    // Directed arithmetic cases, one element per tile.
    rdyMode = 0; rdyVal = 1'b1;
    applyStimulus(100, 5, 3, -10, 1);
    applyStimulus(-3, 1, 1, 0, 1);
    applyStimulus(3, 1, 1, 0, 1);
    applyStimulus(7, 1, 0, 0, 1);
    applyStimulus(1000, 3, 4, 0, 1);
    applyStimulus(-1000, 200, 2, 0, 1);
    applyStimulus(0, 0, 0, 127, 1);
    drain();

    // Backpressure: ten back-to-back inputs, downstream stalled for cycles 4..9.
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      rdyVal   = (c < 4 || c > 9);
      drvData  = IN_W'(sent * 1000 - 4000);
      drvMult  = MULT_W'(3);
      drvShift = SHIFT_W'(2);
      drvAdd   = WI'(1);
      drvLen   = '0;
      drvValid = (sent < 10);
      tick();
      if (accepted) sent++;
      if (c >= 4 && c <= 9) checkOutput("bp_ready_o", longint'(ready_o), 0);
    end
    drvValid = 1'b0;
    rdyVal = 1'b1;
    checkOutput("bp_sent", longint'(sent), 10);
    drain();

    // Tiles: length 4, then length 2 requested mid-tile, then length 0.
    rdyMode = 1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(longint'($signed(IN_W'($urandom))), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 255)) - 128,
                    (i < 5) ? 4 : 2);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(longint'($urandom_range(0, 200)) - 100, 1, 0, 0, 0);
    end
    drain();

    // Reset with three elements held, then a fresh two-element tile.
    rdyMode = 0; rdyVal = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(50 + i, 2, 1, 3, 5);
    doReset();
    rdyVal = 1'b1;
    applyStimulus(-20, 7, 2, 5, 2);
    applyStimulus(40, 9, 3, -4, 2);
    drain();

    // Random traffic with random gaps and random downstream readiness.
    rdyMode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drvValid = 1'b0;
        tick();
      end
      applyStimulus(longint'($signed(IN_W'($urandom))), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                : int'($urandom_range(10, 24)),
                    int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 5)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ita_gelu_requant.md
# ita_gelu_requant

Streaming requantizer directly downstream of the GELU stage. It takes wide signed GELU products and applies a per-element multiplier, a rounding arithmetic right shift and a signed offset. It saturates the result to a signed WI-bit value, so the activation output returns to the int8 datapath. The block is a 3-stage valid/ready pipeline with full backpressure and a tile element counter that flags the last element of each tile.

## Interface
Parameters:
- IN_W, 26, width of signed GELU output word (matches gelu_out_t)
- WI, 8, signed output width (matches requant_t)
- MULT_W, 8, unsigned multiplier width
- SHIFT_W, 5, unsigned shift-amount width
- LEN_W, 16, tile-length counter width

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input word valid
- ready_o  out  1  block can accept input this cycle
- data_i  in  IN_W  signed GELU result
- mult_i  in  MULT_W  unsigned requant multiplier (eps_mult)
- shift_i  in  SHIFT_W  right-shift amount, 0..2^SHIFT_W-1
- add_i  in  WI  signed post-shift offset
- len_i  in  LEN_W  elements per tile; sampled when the first element of a tile is accepted
- valid_o  out  1  output word valid
- ready_i  in  1  downstream accepts output
- data_o  out  WI  saturated signed result
- last_o  out  1  qualifies data_o as last element of the tile

## Operation
- Handshake transfer happens when valid && ready on the same edge. mult_i, shift_i and add_i are captured with data_i on input transfer and follow the element, so changing constants mid-stream is legal.
- S1: signed product P = data_i * $signed({1'b0, mult_i}), width IN_W+MULT_W+1. This stage also registers shift and add.
- S2: if shift == 0, R = P. Otherwise R = (P + 2^(shift-1)) >>> shift, computed in one extra guard bit so the rounding add cannot overflow. Rounding is half toward +infinity. The stage then computes S = R + sign-extended add.
- S3: clamp S to [-2^(WI-1), 2^(WI-1)-1] and register the result into data_o.
- Each stage register loads when it is empty or its content is leaving downstream in the same cycle. Stage k ready = !valid_k || ready_(k+1), with ready_4 = ready_i. ready_o is the S1 ready, so holes in the pipeline collapse (bubble-free).
- Element counter:
  - Increments on each output transfer.
  - last_o = (cnt == len_q - 1). On the cycle an element with last_o transfers out, cnt returns to 0.
  - len_q is captured on the input transfer that occurs while no element of the current tile has entered yet (tile-start flag, cleared on that transfer, set again when the tile's last element enters).
  - len_i == 0 is treated as 1, so every element is last.
- Counter wrap: cnt never exceeds len_q-1. With LEN_W=16 the maximum tile is 65535 elements.

## Timing
- Latency: 3 cycles from input transfer to valid_o high, with no stall.
- Throughput: 1 element/cycle while ready_i is high.
- Storage: 3 elements. With ready_i low, ready_o drops after 3 accepted elements. ready_o rises in the same cycle ready_i rises (combinational path ready_i -> ready_o permitted).
- Outputs hold while valid_o && !ready_i. data_o and last_o must not change until transfer.
- Order is strictly FIFO; no element is dropped or duplicated.
- Reset, including mid-operation:
  - All stage valids, cnt and len_q are cleared, and the tile-start flag is set.
  - valid_o=0, data_o=0, last_o=0 from the cycle after rst_i is sampled high.
  - ready_o=0 while rst_i is high.
  - In-flight elements are discarded.
- Simultaneous input and output transfers on a full pipeline are legal: one element enters and one leaves in the same cycle.

## Test plan
- Basic: data 100, mult 5, shift 3, add -10, ready_i=1 -> 3 cycles later data_o=53 (500+4=504>>>3=63; 63-10=53).
- Rounding/negative: data -3, mult 1, shift 1, add 0 -> -1. data 3, mult 1, shift 1 -> 2. data 7, mult 1, shift 0, add 0 -> 7.
- Saturation: data 1000, mult 3, shift 4, add 0 -> 127. data -1000, mult 200, shift 2, add 0 -> -128. data 0, mult 0, add 127 -> 127.
- Backpressure: 10 consecutive inputs, ready_i low for cycles 4-9 -> ready_o low after 3 held elements; all 10 outputs emerge in order with stable data_o while stalled.
- Tiles: len_i=4, 9 elements, random ready_i -> last_o on the 4th and 8th outputs only. Changing len_i to 2 mid-tile takes effect at the next tile. len_i=0 -> last_o on every output.
- Reset mid-stream: assert rst_i for 1 cycle with 3 elements in flight -> valid_o=0, data_o=0, last_o=0 next cycle. Afterwards, a new 2-element tile (len_i=2) gives last_o on its 2nd output.
